// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_sequencer_pkg                                                   |
// | Song-entry field layout, state encoding and entry decode helpers.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package note_sequencer_pkg;

  localparam int END_BIT   = 15;
  localparam int SHIFT_MSB = 14;
  localparam int SHIFT_LSB = 13;
  localparam int NOTES_MSB = 12;
  localparam int NOTES_LSB = 5;
  localparam int DUR_MSB   = 4;
  localparam int DUR_LSB   = 0;
  localparam int DUR_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_ROM = 3'd2,
    S_PLAY     = 3'd3,
    S_GAP      = 3'd4
  } seq_state_t;

  function automatic logic entry_is_end(input logic [15:0] e);
    return e[END_BIT];
  endfunction

  function automatic logic [1:0] entry_shift(input logic [15:0] e);
    return e[SHIFT_MSB:SHIFT_LSB];
  endfunction

  function automatic logic [7:0] entry_notes(input logic [15:0] e);
    return e[NOTES_MSB:NOTES_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [15:0] e);
    return e[DUR_MSB:DUR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_unit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unit_timer                                                           |
// | Count-to-N counter with clear, enable and a wrap pulse on N-1.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module unit_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam int              c_width = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_width-1:0] c_last = c_width'(N - 1);

  logic [c_width-1:0] r_cnt;

  assign wrap = en && (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_sequencer                                                       |
// | Song-table autoplay: fetches entries from a sync ROM and drives      |
// | notes/shift for each duration, with a silent gap between entries.    |
// | Build option SEQ_LOOP_EN: end entry restarts from the start address. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TICKS_PER_UNIT = 2500000,
  parameter int GAP_CYCLES     = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        notes,
  output logic [1:0]        shift,
  output logic              busy,
  output logic              done
);

  seq_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_next;
  logic [7:0]        r_notes, w_notes_next;
  logic [7:0]        r_entry_notes, w_entry_notes_next;
  logic [1:0]        r_shift, w_shift_next;
  logic [DUR_W-1:0]  r_remain, w_remain_next;
  logic              r_done, w_done_next;
  logic              w_tick_en, w_tick_wrap;
  logic              w_gap_en, w_gap_wrap;
`ifdef SEQ_LOOP_EN
  logic [ADDR_W-1:0] r_start_addr, w_start_addr_next;
`endif

  // Both timers stay cleared outside their own state, so each entry starts from zero.
  assign w_tick_en = (r_state == S_PLAY) && !pause;
  assign w_gap_en  = (r_state == S_GAP) && !pause;

  unit_timer #(.N(TICKS_PER_UNIT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state != S_PLAY),
    .en    (w_tick_en),
    .wrap  (w_tick_wrap)
  );

  unit_timer #(.N(GAP_CYCLES)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state != S_GAP),
    .en    (w_gap_en),
    .wrap  (w_gap_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rom_addr    <= '0;
      r_notes       <= '0;
      r_entry_notes <= '0;
      r_shift       <= '0;
      r_remain      <= '0;
      r_done        <= 1'b0;
`ifdef SEQ_LOOP_EN
      r_start_addr  <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_rom_addr    <= w_rom_addr_next;
      r_notes       <= w_notes_next;
      r_entry_notes <= w_entry_notes_next;
      r_shift       <= w_shift_next;
      r_remain      <= w_remain_next;
      r_done        <= w_done_next;
`ifdef SEQ_LOOP_EN
      r_start_addr  <= w_start_addr_next;
`endif
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_rom_addr_next    = r_rom_addr;
    w_entry_notes_next = r_entry_notes;
    w_shift_next       = r_shift;
    w_remain_next      = r_remain;
    w_notes_next       = 8'h00;
    w_done_next        = 1'b0;
`ifdef SEQ_LOOP_EN
    w_start_addr_next  = r_start_addr;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_FETCH;
          w_rom_addr_next = start_addr;
`ifdef SEQ_LOOP_EN
          w_start_addr_next = start_addr;
`endif
        end
      end
      S_FETCH: w_state_next = S_WAIT_ROM;
      S_WAIT_ROM: begin
        if (entry_is_end(rom_data)) begin
`ifdef SEQ_LOOP_EN
          w_state_next    = S_FETCH;
          w_rom_addr_next = r_start_addr;
`else
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
`endif
        end else if (entry_dur(rom_data) == '0) begin
          w_state_next    = S_FETCH;
          w_rom_addr_next = r_rom_addr + 1'b1;
        end else begin
          w_state_next       = S_PLAY;
          w_remain_next      = entry_dur(rom_data);
          w_entry_notes_next = entry_notes(rom_data);
          w_shift_next       = entry_shift(rom_data);
          w_notes_next       = entry_notes(rom_data);
        end
      end
      S_PLAY: begin
        if (w_tick_wrap) begin
          w_remain_next = r_remain - 1'b1;
          if (r_remain == DUR_W'(1)) w_state_next = S_GAP;
        end
        if (w_state_next == S_PLAY && !pause) w_notes_next = r_entry_notes;
      end
      S_GAP: begin
        if (w_gap_wrap) begin
          w_state_next    = S_FETCH;
          w_rom_addr_next = r_rom_addr + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Stop overrides everything, including a start seen in the same cycle.
    if (stop) begin
      w_state_next    = S_IDLE;
      w_rom_addr_next = r_rom_addr;
      w_notes_next    = 8'h00;
      w_done_next     = 1'b0;
`ifdef SEQ_LOOP_EN
      w_start_addr_next = r_start_addr;
`endif
    end
  end

  assign rom_addr = r_rom_addr;
  assign notes    = r_notes;
  assign shift    = r_shift;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_note_sequencer                                                    |
// | Directed and random stimulus against a phase-queue reference model.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_note_sequencer;

  localparam int AW    = 4;
  localparam int TPU   = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause;
  logic [AW-1:0] start_addr, rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    notes;
  logic [1:0]    shift;
  logic          busy, done;
  logic [15:0]   rom [DEPTH];

  note_sequencer #(.ADDR_W(AW), .TICKS_PER_UNIT(TPU), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .start_addr(start_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .notes(notes), .shift(shift), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference model: every busy cycle is one queued phase; PLAY/GAP phases
  // are only consumed on cycles where pause is low.
  typedef enum int {K_FETCH, K_WAIT, K_PLAY, K_GAP} kind_t;
  typedef struct { kind_t k; logic [AW-1:0] a; } phase_t;
  phase_t        q[$];
  bit            m_active, m_done, m_muted;
  logic [AW-1:0] m_start;
  logic [7:0]    m_notes;
  logic [1:0]    m_shift;

  int            n_checks = 0, n_fail = 0;
  int            cnt_notes, cnt_done, cnt_onsets;
  logic [7:0]    prev_notes;
  logic [AW-1:0] addr_seq[$];
  bit            chk_on = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic e, input logic [1:0] sh, input logic [7:0] n,
                                      input logic [4:0] d);
    return {e, sh, n, d};
  endfunction

  function automatic void push_entry(input logic [AW-1:0] a);
    q.push_back('{K_FETCH, a});
    q.push_back('{K_WAIT, a});
  endfunction

  function automatic void decode(input logic [AW-1:0] a);
    logic [15:0] e = rom[a];
    int units = int'(e[4:0]);
    if (e[15]) begin
`ifdef SEQ_LOOP_EN
      push_entry(m_start);
`else
      m_active = 0;
      m_done   = 1;
`endif
    end else if (units == 0) begin
      push_entry(AW'(a + 1));
    end else begin
      m_notes = e[12:5];
      m_shift = e[14:13];
      for (int i = 0; i < units * TPU; i++) q.push_back('{K_PLAY, a});
      for (int i = 0; i < GAP; i++) q.push_back('{K_GAP, a});
    end
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit sp, input bit p,
                                     input logic [AW-1:0] sa);
    phase_t cur;
    m_done  = 0;
    m_muted = 0;
    if (r) begin
      m_active = 0;
      q.delete();
      m_shift = 2'd0;
    end else if (!m_active) begin
      if (s && !sp) begin
        m_active = 1;
        m_start  = sa;
        push_entry(sa);
      end
    end else if (sp) begin
      m_active = 0;
      q.delete();
    end else begin
      cur = q[0];
      if ((cur.k == K_PLAY || cur.k == K_GAP) && p) begin
        m_muted = 1;
      end else begin
        void'(q.pop_front());
        if (cur.k == K_WAIT) decode(cur.a);
        else if (cur.k == K_GAP && q.size() == 0) push_entry(AW'(cur.a + 1));
      end
    end
  endfunction

  function automatic logic [7:0] exp_notes();
    return (m_active && q[0].k == K_PLAY && !m_muted) ? m_notes : 8'h00;
  endfunction

  task automatic step(input bit s, input bit sp, input bit p, input logic [AW-1:0] sa, input bit r);
    start = s; stop = sp; pause = p; start_addr = sa; rst = r;
    @(negedge clk);
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("notes", 32'(notes), 32'(exp_notes()));
      if (m_active) begin
        check("rom_addr", 32'(rom_addr), 32'(q[0].a));
        if (q[0].k == K_PLAY) check("shift", 32'(shift), 32'(m_shift));
      end
    end
    if (notes != 8'h00) cnt_notes++;
    if (notes != 8'h00 && prev_notes == 8'h00) cnt_onsets++;
    prev_notes = notes;
    if (done) cnt_done++;
    if (busy && (addr_seq.size() == 0 || addr_seq[$] != rom_addr)) addr_seq.push_back(rom_addr);
    @(posedge clk);
    model_step(r, s, sp, p, sa);
    #1;
  endtask

  task automatic idle(input int n, input bit p);
    repeat (n) step(0, 0, p, '0, 0);
  endtask

  task automatic clear_cnts();
    cnt_notes = 0; cnt_done = 0; cnt_onsets = 0; prev_notes = 8'h00;
    addr_seq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_notes"}, 32'(notes), 32'd0);
    check({tag, "_shift"}, 32'(shift), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p_rand;
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h8000;
    repeat (3) step(0, 0, 0, '0, 1);
    check_reset_outputs("reset");
    chk_on = 1;
    idle(2, 0);

    // Single entry followed by an end entry
    rom[5] = enc(1'b0, 2'd1, 8'h01, 5'd3);
    rom[6] = 16'h8000;
    clear_cnts();
    step(1, 0, 0, AW'(5), 0);
    idle(24, 0);
`ifndef SEQ_LOOP_EN
    check("t1_note_cycles", 32'(cnt_notes), 32'd12);
    check("t1_done_pulses", 32'(cnt_done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
`endif
    step(0, 1, 0, '0, 0);
    idle(2, 0);

    // Zero-duration entry is skipped
    rom[0] = enc(1'b0, 2'd0, 8'h22, 5'd0);
    rom[1] = enc(1'b0, 2'd3, 8'h04, 5'd1);
    rom[2] = 16'h8000;
    clear_cnts();
    step(1, 0, 0, AW'(0), 0);
    idle(18, 0);
`ifndef SEQ_LOOP_EN
    check("t2_note_cycles", 32'(cnt_notes), 32'd4);
    check("t2_onsets", 32'(cnt_onsets), 32'd1);
`endif
    step(0, 1, 0, '0, 0);
    idle(2, 0);

    // Pause for 10 cycles after 5 played cycles; registered notes lag pause by one cycle
    rom[8] = enc(1'b0, 2'd2, 8'h40, 5'd3);
    rom[9] = 16'h8000;
    clear_cnts();
    step(1, 0, 0, AW'(8), 0);
    for (int i = 0; i < 40 && cnt_notes < 5; i++) step(0, 0, 0, '0, 0);
    check("t3_pre_pause", 32'(cnt_notes), 32'd5);
    idle(10, 1);
    check("t3_in_pause", 32'(cnt_notes), 32'd6);
    idle(14, 0);
    check("t3_total", 32'(cnt_notes), 32'd12);
    check("t3_onsets", 32'(cnt_onsets), 32'd2);
    step(0, 1, 0, '0, 0);
    idle(2, 0);

    // Start and stop together in IDLE, then stop mid-PLAY
    clear_cnts();
    step(1, 1, 0, AW'(5), 0);
    check("t4_race_busy", 32'(busy), 32'd0);
    idle(2, 0);
    check("t4_race_busy2", 32'(busy), 32'd0);
    step(1, 0, 0, AW'(5), 0);
    for (int i = 0; i < 20 && cnt_notes < 3; i++) step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    check("t4_stop_notes", 32'(notes), 32'd0);
    check("t4_stop_busy", 32'(busy), 32'd0);
    idle(20, 0);
    check("t4_no_done", 32'(cnt_done), 32'd0);

    // Address wraps from all-ones to zero
    rom[15] = enc(1'b0, 2'd2, 8'h80, 5'd1);
    rom[0]  = 16'h8000;
    clear_cnts();
    step(1, 0, 0, AW'(15), 0);
    idle(14, 0);
    check("t5_addr0", 32'(addr_seq[0]), 32'd15);
    check("t5_addr1", 32'(addr_seq[1]), 32'd0);
`ifndef SEQ_LOOP_EN
    check("t5_addr_count", 32'(addr_seq.size()), 32'd2);
    check("t5_done_pulses", 32'(cnt_done), 32'd1);
`endif
    step(0, 1, 0, '0, 0);
    idle(2, 0);

    rom[10] = enc(1'b0, 2'd1, 8'h10, 5'd1);
    rom[11] = 16'h8000;
`ifdef SEQ_LOOP_EN
    // Looping song repeats until stopped, never pulsing done
    clear_cnts();
    step(1, 0, 0, AW'(10), 0);
    idle(60, 0);
    check("t6_repeats", 32'(cnt_onsets >= 3), 32'd1);
    check("t6_no_done", 32'(cnt_done), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
`endif
    // Reset in the middle of playback
    step(1, 0, 0, AW'(10), 0);
    idle(4, 0);
    step(0, 0, 0, '0, 1);
    check_reset_outputs("t7_rst");
    idle(2, 0);

    // Random song table with random control traffic
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 99) < 12) rom[i] = 16'h8000;
      else rom[i] = enc(1'b0, 2'($urandom), 8'($urandom), 5'($urandom_range(0, 3)));
    end
    p_rand = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) p_rand = ~p_rand;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, p_rand,
           AW'($urandom), $urandom_range(0, 999) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
